// File: rtl/lzc_pipelined.sv
// Two-stage pipelined leading/trailing zero counter with normalising shift.
// Stage 1 computes per-group counts; stage 2 priority-encodes groups and shifts.
module lzc_pipelined #(
   parameter int WIDTH = 24,
   parameter int GROUP = 4,
   parameter int TAG_W = 4,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   input  logic             in_trailing,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_zeros,
   output logic             out_all_zero,
   output logic [WIDTH-1:0] out_norm,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NG  = (WIDTH + GROUP - 1) / GROUP;
   localparam int PW  = NG * GROUP;
   localparam int GCW = $clog2(GROUP);

   logic             s1_en;
   logic             s2_en;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_value;
   logic             s1_trailing;
   logic [TAG_W-1:0] s1_tag;
   logic [GCW-1:0]   s1_cnt [NG];
   logic [NG-1:0]    s1_zero;

   logic [WIDTH-1:0] src;
   logic [PW-1:0]    padded;
   logic [GROUP-1:0] grp_bits [NG];
   logic [GCW-1:0]   grp_cnt  [NG];
   logic [NG-1:0]    grp_zero;

   logic [CW-1:0]    enc;
   logic             enc_all_zero;
   logic [WIDTH-1:0] shifted;

   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en;

   // Trailing mode reverses the operand so a single MSB-first datapath serves both.
   // Ones padding below the real bits caps the count at WIDTH.
   always_comb begin
      src = in_value;
      for (int i = 0; i < WIDTH; i++) begin
         src[i] = in_trailing ? in_value[WIDTH-1-i] : in_value[i];
      end
      padded = '1;
      padded[PW-1 -: WIDTH] = src;
   end

   // Group 0 is the most significant group of the padded vector.
   always_comb begin
      for (int g = 0; g < NG; g++) begin
         grp_bits[g] = padded[PW-1-g*GROUP -: GROUP];
         grp_zero[g] = (grp_bits[g] == '0);
         grp_cnt[g]  = '0;
         for (int b = 0; b < GROUP; b++) begin
            if (grp_bits[g][b]) grp_cnt[g] = GCW'(GROUP - 1 - b);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid    <= 1'b0;
         s1_value    <= '0;
         s1_trailing <= 1'b0;
         s1_tag      <= '0;
         s1_zero     <= '0;
         for (int g = 0; g < NG; g++) s1_cnt[g] <= '0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_value    <= in_value;
            s1_trailing <= in_trailing;
            s1_tag      <= in_tag;
            s1_zero     <= grp_zero;
            for (int g = 0; g < NG; g++) s1_cnt[g] <= grp_cnt[g];
         end
      end
   end

   // Lowest-numbered non-zero group wins, so scan downward and let the last hit stand.
   always_comb begin
      int t;
      t   = 0;
      enc = CW'(WIDTH);
      for (int g = NG - 1; g >= 0; g--) begin
         if (!s1_zero[g]) begin
            t   = g * GROUP + int'(s1_cnt[g]);
            enc = CW'(t);
         end
      end
      enc_all_zero = (s1_value == '0);
      if (enc_all_zero) enc = CW'(WIDTH);
      shifted = s1_trailing ? (s1_value >> enc) : (s1_value << enc);
      if (enc >= CW'(WIDTH)) shifted = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid    <= 1'b0;
         out_zeros    <= '0;
         out_all_zero <= 1'b0;
         out_norm     <= '0;
         out_tag      <= '0;
      end else if (s2_en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_zeros    <= enc;
            out_all_zero <= enc_all_zero;
            out_norm     <= shifted;
            out_tag      <= s1_tag;
         end
      end
   end

endmodule

// File: tb/tb_lzc_pipelined.sv
// Directed bench for lzc_pipelined: vector table, latency, back-pressure,
// mid-flight reset, and a padded WIDTH=23 instance.
module tb_lzc_pipelined;

   typedef struct {
      logic        trailing;
      logic [23:0] value;
      logic [3:0]  tag;
      logic [4:0]  zeros;
      logic        all_zero;
      logic [23:0] norm;
   } vec_t;

   typedef struct {
      logic        trailing;
      logic [22:0] value;
      logic [4:0]  zeros;
      logic        all_zero;
      logic [22:0] norm;
   } vec23_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, in_trailing, out_valid, out_ready, out_all_zero;
   logic [23:0] in_value, out_norm;
   logic [3:0]  in_tag, out_tag;
   logic [4:0]  out_zeros;

   logic        in_valid23, in_ready23, in_trailing23, out_valid23, out_all_zero23;
   logic [22:0] in_value23, out_norm23;
   logic [3:0]  in_tag23, out_tag23;
   logic [4:0]  out_zeros23;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          or_mode = 0;  // 0: out_ready=1, 1: random, 2: out_ready=0
   vec_t        exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lzc_pipelined #(.WIDTH(24), .GROUP(4), .TAG_W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
      .in_trailing(in_trailing), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_zeros(out_zeros),
      .out_all_zero(out_all_zero), .out_norm(out_norm), .out_tag(out_tag)
   );

   lzc_pipelined #(.WIDTH(23), .GROUP(4), .TAG_W(4)) dut23 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid23), .in_ready(in_ready23), .in_value(in_value23),
      .in_trailing(in_trailing23), .in_tag(in_tag23),
      .out_valid(out_valid23), .out_ready(1'b1), .out_zeros(out_zeros23),
      .out_all_zero(out_all_zero23), .out_norm(out_norm23), .out_tag(out_tag23)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t ref_calc(input logic tr, input logic [23:0] v, input logic [3:0] tg);
      vec_t r;
      int   n;
      n = 24;
      for (int k = 0; k < 24; k++) begin
         if ((tr ? v[k] : v[23-k]) && n == 24) n = k;
      end
      r.trailing = tr;
      r.value    = v;
      r.tag      = tg;
      r.zeros    = 5'(n);
      r.all_zero = (v == 24'h0);
      r.norm     = (n >= 24) ? 24'h0 : (tr ? (v >> n) : (v << n));
      return r;
   endfunction

   // out_ready is changed just after each rising edge
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Scoreboard and hold-stability monitor, sampled on falling edges
   initial begin
      logic        held;
      logic [4:0]  h_z;
      logic        h_az;
      logic [23:0] h_n;
      logic [3:0]  h_t;
      vec_t        e;
      held = 1'b0;
      h_z = '0; h_az = 1'b0; h_n = '0; h_t = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_zeros", 32'(out_zeros), 32'(h_z));
               check("stall_norm", 32'(out_norm), 32'(h_n));
               check("stall_tag", 32'({out_all_zero, out_tag}), 32'({h_az, h_t}));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("zeros", 32'(out_zeros), 32'(e.zeros));
                  check("all_zero", 32'(out_all_zero), 32'(e.all_zero));
                  check("norm", 32'(out_norm), 32'(e.norm));
                  check("tag", 32'(out_tag), 32'(e.tag));
               end
            end
            held = out_valid && !out_ready;
            h_z = out_zeros; h_az = out_all_zero; h_n = out_norm; h_t = out_tag;
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input vec_t e);
      in_valid    = 1'b1;
      in_value    = e.value;
      in_trailing = e.trailing;
      in_tag      = e.tag;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
      check("drain_left", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Operand is presented just after edge E0; out_valid must be low after E1, high after E2.
   task automatic latency_check(input vec_t e);
      in_valid    = 1'b1;
      in_value    = e.value;
      in_trailing = e.trailing;
      in_tag      = e.tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("latency_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("latency_on_time", 32'(out_valid), 32'd1);
      wait_drain();
   endtask

   initial begin
      vec_t   tbl[$];
      vec23_t t23[$];
      int     c0;

      tbl.push_back('{1'b0, 24'h00F000, 4'd3, 5'd8,  1'b0, 24'hF00000});
      tbl.push_back('{1'b1, 24'h000A00, 4'd4, 5'd9,  1'b0, 24'h000005});
      tbl.push_back('{1'b1, 24'h800000, 4'd5, 5'd23, 1'b0, 24'h000001});
      tbl.push_back('{1'b0, 24'h000000, 4'd6, 5'd24, 1'b1, 24'h000000});
      tbl.push_back('{1'b1, 24'h000000, 4'd7, 5'd24, 1'b1, 24'h000000});
      tbl.push_back('{1'b0, 24'h800000, 4'd8, 5'd0,  1'b0, 24'h800000});
      tbl.push_back('{1'b0, 24'h000001, 4'd9, 5'd23, 1'b0, 24'h800000});
      tbl.push_back('{1'b1, 24'h000001, 4'hA, 5'd0,  1'b0, 24'h000001});
      tbl.push_back('{1'b0, 24'h0ABCDE, 4'hB, 5'd4,  1'b0, 24'hABCDE0});
      tbl.push_back('{1'b1, 24'h123400, 4'hC, 5'd10, 1'b0, 24'h00048D});
      tbl.push_back('{1'b0, 24'h000030, 4'hD, 5'd18, 1'b0, 24'hC00000});

      t23.push_back('{1'b0, 23'h000001, 5'd22, 1'b0, 23'h400000});
      t23.push_back('{1'b0, 23'h000000, 5'd23, 1'b1, 23'h000000});
      t23.push_back('{1'b1, 23'h000000, 5'd23, 1'b1, 23'h000000});
      t23.push_back('{1'b1, 23'h400000, 5'd22, 1'b0, 23'h000001});
      t23.push_back('{1'b0, 23'h400000, 5'd0,  1'b0, 23'h400000});
      t23.push_back('{1'b0, 23'h000300, 5'd13, 1'b0, 23'h600000});

      in_valid = 1'b0; in_value = '0; in_trailing = 1'b0; in_tag = '0;
      in_valid23 = 1'b0; in_value23 = '0; in_trailing23 = 1'b0; in_tag23 = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_outputs", 32'({out_zeros, out_all_zero, out_tag}), 32'd0);
      check("rst_norm", 32'(out_norm), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      latency_check(tbl[0]);

      // Back-to-back table stream must take exactly one cycle per operand
      c0 = cyc;
      for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
      check("throughput_cycles", 32'(cyc - c0), 32'(tbl.size()));
      wait_drain();

      // Random back-pressure with a 10-operand stream
      or_mode = 1;
      for (int i = 0; i < 10; i++) begin
         logic [23:0] v;
         v = 24'($urandom()) >> $urandom_range(0, 24);
         send(ref_calc(1'($urandom_range(0, 1)), v, 4'(i)));
      end
      wait_drain();
      or_mode = 0;

      // Reset with two operands in flight
      or_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send(ref_calc(1'b0, 24'h001234, 4'h1));
      send(ref_calc(1'b1, 24'h030000, 4'h2));
      check("inflight_out_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      exp_q.delete();
      or_mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("no_stale_after_rst", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      latency_check(ref_calc(1'b1, 24'h0000C0, 4'hE));

      // Padded width instance
      for (int i = 0; i < t23.size(); i++) begin
         in_valid23    = 1'b1;
         in_value23    = t23[i].value;
         in_trailing23 = t23[i].trailing;
         in_tag23      = 4'(i);
         check("w23_in_ready", 32'(in_ready23), 32'd1);
         @(posedge clk);
         #1;
         in_valid23 = 1'b0;
         @(posedge clk);
         #1;
         check("w23_valid", 32'(out_valid23), 32'd1);
         check("w23_zeros", 32'(out_zeros23), 32'(t23[i].zeros));
         check("w23_all_zero", 32'(out_all_zero23), 32'(t23[i].all_zero));
         check("w23_norm", 32'(out_norm23), 32'(t23[i].norm));
         check("w23_tag", 32'(out_tag23), 32'(i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
